// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and the host halfword width.
package prog_loader_pkg;

  localparam int unsigned HW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Loads a halfword-streamed program into instruction memory while holding the core in reset.
// Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum halfword before DONE.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [HW-1:0] data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  // One extra bit so the word counter can hold N == DEPTH == 2**AW.
  localparam int unsigned CW = AW + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n_words;
  logic [HW-1:0] hi_q;
`ifdef PROG_LOADER_CSUM_EN
  logic [HW-1:0] csum;
`endif

  logic          xfer_c;
  logic          len_bad_c;
  logic [CW-1:0] cnt_inc_c;

  assign xfer_c    = data_valid && data_ready;
  assign len_bad_c = (data_in == '0) || (32'(data_in) > DEPTH);
  assign cnt_inc_c = cnt + CW'(1);

  // Loader FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      n_words    <= '0;
      hi_q       <= '0;
      data_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN;
            cnt        <= '0;
            data_ready <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst   <= 1'b1;
          end
        end
        S_LEN: begin
          if (xfer_c) begin
`ifdef PROG_LOADER_CSUM_EN
            csum <= data_in;
`endif
            if (len_bad_c) begin
              state      <= S_ERR;
              data_ready <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
            end else begin
              state   <= S_HI;
              n_words <= CW'(data_in);
            end
          end
        end
        S_HI: begin
          if (xfer_c) begin
            state <= S_LO;
            hi_q  <= data_in;
`ifdef PROG_LOADER_CSUM_EN
            csum  <= csum ^ data_in;
`endif
          end
        end
        S_LO: begin
          if (xfer_c) begin
            state      <= S_WRITE;
            data_ready <= 1'b0;
            mem_we     <= 1'b1;
            mem_addr   <= cnt[AW-1:0];
            mem_wdata  <= {hi_q, data_in};
`ifdef PROG_LOADER_CSUM_EN
            csum       <= csum ^ data_in;
`endif
          end
        end
        S_WRITE: begin
          cnt <= cnt_inc_c;
          if (cnt_inc_c == n_words) begin
`ifdef PROG_LOADER_CSUM_EN
            state      <= S_CSUM;
            data_ready <= 1'b1;
`else
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_rst   <= 1'b0;
`endif
          end else begin
            state      <= S_HI;
            data_ready <= 1'b1;
          end
        end
`ifdef PROG_LOADER_CSUM_EN
        S_CSUM: begin
          if (xfer_c) begin
            data_ready <= 1'b0;
            busy       <= 1'b0;
            if (data_in == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          data_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
